// File: rtl/game_pkg.sv
// Shared encodings for the game sequencer and the VGA display stage.
// Pure declarations: no latency, no flow control.
package game_pkg;

  typedef enum logic [2:0] {
    MODE_TITLE  = 3'b000,
    MODE_GAME   = 3'b001,
    MODE_INBET  = 3'b010,
    MODE_WIN    = 3'b011,
    MODE_G_OVER = 3'b100
  } mode_e;

  // Three packed BCD digits {hundreds, tens, ones}
  typedef logic [11:0] bcd_score_t;

  localparam bcd_score_t SCORE_MAX = 12'h999;

endpackage

// File: rtl/bcd_add_sat.sv
// Adds a 3-bit binary value to a 3-digit BCD score, saturating at 999.
// Combinational, zero latency; no backpressure.
module bcd_add_sat
  import game_pkg::*;
(
  input  bcd_score_t a,
  input  logic [2:0] addend,
  output bcd_score_t sum
);

  logic [4:0] d0, d1, d2;
  logic       c0, c1, c2;

  always_comb begin
    d0 = {1'b0, a[3:0]} + {2'b00, addend};
    c0 = (d0 > 5'd9);
    if (c0) d0 = d0 - 5'd10;

    d1 = {1'b0, a[7:4]} + {4'b0000, c0};
    c1 = (d1 > 5'd9);
    if (c1) d1 = d1 - 5'd10;

    d2 = {1'b0, a[11:8]} + {4'b0000, c1};
    c2 = (d2 > 5'd9);
    if (c2) d2 = d2 - 5'd10;

    // A carry out of the hundreds digit means the true sum passed 999
    sum = c2 ? SCORE_MAX : {d2[3:0], d1[3:0], d0[3:0]};
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: screen mode, level, lives and BCD score from collision events.
// Outputs registered, one cycle after the triggering edge; events outside GAME are dropped.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int MAX_LEVEL    = 5,
  parameter int START_LIVES  = 3,
  parameter int INBET_FRAMES = 120,
  parameter int END_FRAMES   = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        ship_hit,
  input  logic        player_hit,
  input  logic        wave_clear,
  output logic [2:0]  mode,
  output logic [2:0]  level,
  output logic [11:0] score,
  output logic [1:0]  lives,
  output logic        wave_start
);

  localparam logic [2:0] LVL_LAST   = 3'(MAX_LEVEL);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [9:0] INBET_CNT  = 10'(INBET_FRAMES);
  localparam logic [9:0] END_CNT    = 10'(END_FRAMES);

  mode_e      mode_q, mode_d;
  logic [2:0] level_q, level_d;
  bcd_score_t score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic       wave_start_q, wave_start_d;
  logic [9:0] cnt_q, cnt_d;
  logic       start_q, start_d;

  logic       start_press;
  logic [9:0] cnt_inc;
  bcd_score_t score_sum;

  assign start_press = start_btn & ~start_q;
  assign cnt_inc     = cnt_q + 10'd1;

  bcd_add_sat u_bcd_add_sat (
    .a      (score_q),
    .addend (level_q),
    .sum    (score_sum)
  );

  always_comb begin
    mode_d       = mode_q;
    level_d      = level_q;
    score_d      = score_q;
    lives_d      = lives_q;
    cnt_d        = cnt_q;
    wave_start_d = 1'b0;
    start_d      = start_btn;

    case (mode_q)
      MODE_TITLE: begin
        if (start_press) begin
          mode_d       = MODE_GAME;
          level_d      = 3'd1;
          score_d      = '0;
          lives_d      = LIVES_INIT;
          cnt_d        = '0;
          wave_start_d = 1'b1;
        end
      end
      MODE_GAME: begin
        if (ship_hit) score_d = score_sum;
        // A fatal hit wins over a simultaneous wave_clear
        if (player_hit && lives_q == 2'd1) begin
          lives_d = 2'd0;
          mode_d  = MODE_G_OVER;
          cnt_d   = '0;
        end else begin
          if (player_hit) lives_d = lives_q - 2'd1;
          if (wave_clear) begin
            mode_d = (level_q == LVL_LAST) ? MODE_WIN : MODE_INBET;
            cnt_d  = '0;
          end
        end
      end
      MODE_INBET: begin
        if (frame_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == INBET_CNT) begin
            mode_d       = MODE_GAME;
            level_d      = level_q + 3'd1;
            cnt_d        = '0;
            wave_start_d = 1'b1;
          end
        end
      end
      MODE_WIN, MODE_G_OVER: begin
        if (frame_tick) cnt_d = cnt_inc;
        // Score and level are left alone so the end screens can show them
        if (start_press || (frame_tick && cnt_inc == END_CNT)) begin
          mode_d = MODE_TITLE;
          cnt_d  = '0;
        end
      end
      default: begin
        mode_d = MODE_TITLE;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_TITLE;
      level_q      <= 3'd1;
      score_q      <= '0;
      lives_q      <= LIVES_INIT;
      wave_start_q <= 1'b0;
      cnt_q        <= '0;
      start_q      <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      level_q      <= level_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      wave_start_q <= wave_start_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
    end
  end

  assign mode       = mode_q;
  assign level      = level_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign wave_start = wave_start_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: a behavioural model pushes expected outputs per cycle
// into a scoreboard queue, popped and compared after each clock edge.
module tb_game_state_ctrl;
  import game_pkg::*;

  localparam int MAXL  = 5;
  localparam int LIVES = 3;
  localparam int INBF  = 120;
  localparam int ENDF  = 600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, start_btn, ship_hit, player_hit, wave_clear;
  logic [2:0]  mode;
  logic [2:0]  level;
  logic [11:0] score;
  logic [1:0]  lives;
  logic        wave_start;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  mode;
    logic [2:0]  level;
    logic [11:0] score;
    logic [1:0]  lives;
    logic        ws;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state; score kept as a plain integer
  logic [2:0] m_mode;
  int         m_level, m_score, m_lives, m_cnt;
  logic       m_ws, m_startq;

  game_state_ctrl #(
    .MAX_LEVEL(MAXL), .START_LIVES(LIVES), .INBET_FRAMES(INBF), .END_FRAMES(ENDF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
    .ship_hit(ship_hit), .player_hit(player_hit), .wave_clear(wave_clear),
    .mode(mode), .level(level), .score(score), .lives(lives), .wave_start(wave_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_mode = MODE_TITLE; m_level = 1; m_score = 0; m_lives = LIVES;
    m_cnt = 0; m_ws = 1'b0; m_startq = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic st, input logic sh, input logic ph,
                            input logic wc, input logic ft);
    logic press;
    press    = st & ~m_startq;
    m_startq = st;
    m_ws     = 1'b0;
    case (m_mode)
      MODE_TITLE: if (press) begin
        m_mode = MODE_GAME; m_level = 1; m_score = 0; m_lives = LIVES; m_cnt = 0; m_ws = 1'b1;
      end
      MODE_GAME: begin
        if (sh) m_score = (m_score + m_level > 999) ? 999 : m_score + m_level;
        if (ph && m_lives == 1) begin
          m_lives = 0; m_mode = MODE_G_OVER; m_cnt = 0;
        end else begin
          if (ph) m_lives = m_lives - 1;
          if (wc) begin
            m_mode = (m_level == MAXL) ? MODE_WIN : MODE_INBET;
            m_cnt  = 0;
          end
        end
      end
      MODE_INBET: if (ft) begin
        m_cnt++;
        if (m_cnt == INBF) begin
          m_level++; m_mode = MODE_GAME; m_ws = 1'b1; m_cnt = 0;
        end
      end
      default: begin
        if (ft) m_cnt++;
        if (press || m_cnt == ENDF) begin
          m_mode = MODE_TITLE; m_cnt = 0;
        end
      end
    endcase
  endtask

  task automatic cyc(input logic st, input logic sh, input logic ph,
                     input logic wc, input logic ft);
    exp_t e;
    start_btn = st; ship_hit = sh; player_hit = ph; wave_clear = wc; frame_tick = ft;
    model_step(st, sh, ph, wc, ft);
    sb_q.push_back({m_mode, 3'(m_level), to_bcd(m_score), 2'(m_lives), m_ws});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_mode",  12'(mode),       12'(e.mode));
    check("sb_level", 12'(level),      12'(e.level));
    check("sb_score", score,           e.score);
    check("sb_lives", 12'(lives),      12'(e.lives));
    check("sb_ws",    12'(wave_start), 12'(e.ws));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic new_game();
    cyc(1, 0, 0, 0, 0);
    check("start_mode", 12'(mode), 12'h001);
    check("start_ws", 12'(wave_start), 12'h1);
    cyc(0, 0, 0, 0, 0);
  endtask

  // wave_clear then the full between-level hold, landing on level lvl
  task automatic advance_level(input int lvl);
    cyc(0, 0, 0, 1, 0);
    check("inbet_mode", 12'(mode), 12'h002);
    ticks(INBF - 1);
    check("inbet_hold", 12'(mode), 12'h002);
    cyc(0, 0, 0, 0, 1);
    check("adv_mode", 12'(mode), 12'h001);
    check("adv_level", 12'(level), 12'(lvl));
    check("adv_ws", 12'(wave_start), 12'h1);
    cyc(0, 0, 0, 0, 0);
    check("adv_ws_drop", 12'(wave_start), 12'h0);
  endtask

  initial begin
    int ws_cnt;
    rst_n = 1'b0;
    start_btn = 0; ship_hit = 0; player_hit = 0; wave_clear = 0; frame_tick = 0;
    model_reset();
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_mode",  12'(mode),       12'h000);
    check("rst_level", 12'(level),      12'h001);
    check("rst_score", score,           12'h000);
    check("rst_lives", 12'(lives),      12'h003);
    check("rst_ws",    12'(wave_start), 12'h000);

    // Held button gives exactly one press
    ws_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1, 0, 0, 0, 0);
      ws_cnt += int'(wave_start);
    end
    check("hold_ws_count", 12'(ws_cnt), 12'h001);
    check("hold_mode", 12'(mode), 12'h001);
    check("hold_lives", 12'(lives), 12'h003);
    check("hold_score", score, 12'h000);
    cyc(0, 0, 0, 0, 0);

    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("lvl1_score", score, 12'h002);
    advance_level(2);
    advance_level(3);

    for (int i = 0; i < 32; i++) cyc(0, 1, 0, 0, 0);
    check("score_098", score, 12'h098);
    cyc(0, 1, 0, 0, 0);
    check("score_carry", score, 12'h101);
    for (int i = 0; i < 299; i++) cyc(0, 1, 0, 0, 0);
    check("score_998", score, 12'h998);
    cyc(0, 1, 0, 0, 0);
    check("score_sat", score, 12'h999);
    cyc(0, 1, 0, 0, 0);
    check("score_sat_hold", score, 12'h999);

    cyc(0, 0, 1, 0, 0);
    check("lives_dec", 12'(lives), 12'h002);
    cyc(0, 0, 1, 1, 0);
    check("phit_wclr_lives", 12'(lives), 12'h001);
    check("phit_wclr_mode", 12'(mode), 12'h002);
    ticks(INBF);
    check("lvl4_level", 12'(level), 12'h004);

    // Fatal hit beats wave_clear
    cyc(0, 1, 1, 1, 0);
    check("fatal_mode", 12'(mode), 12'h004);
    check("fatal_lives", 12'(lives), 12'h000);
    check("fatal_ws", 12'(wave_start), 12'h000);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 1);
    check("gover_ignore", 12'(mode), 12'h004);
    cyc(1, 0, 0, 0, 0);
    check("gover_press", 12'(mode), 12'h000);
    check("gover_score_held", score, 12'h999);
    check("gover_level_held", 12'(level), 12'h004);
    cyc(0, 0, 0, 0, 0);

    new_game();
    check("ng_level", 12'(level), 12'h001);
    check("ng_score", score, 12'h000);
    for (int l = 2; l <= MAXL; l++) advance_level(l);
    cyc(0, 0, 0, 1, 0);
    check("win_mode", 12'(mode), 12'h003);
    ticks(ENDF - 1);
    check("win_hold", 12'(mode), 12'h003);
    ticks(1);
    check("win_timeout", 12'(mode), 12'h000);

    new_game();
    for (int l = 2; l <= MAXL; l++) advance_level(l);
    cyc(0, 0, 0, 1, 0);
    check("win2_mode", 12'(mode), 12'h003);
    ticks(10);
    cyc(1, 0, 0, 0, 0);
    check("win_press", 12'(mode), 12'h000);
    cyc(0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of INBET
    new_game();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    ticks(5);
    #3 rst_n = 1'b0;
    #2;
    check("arst_mode",  12'(mode),       12'h000);
    check("arst_level", 12'(level),      12'h001);
    check("arst_score", score,           12'h000);
    check("arst_lives", 12'(lives),      12'h003);
    check("arst_ws",    12'(wave_start), 12'h000);
    model_reset();
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    new_game();
    check("post_rst_level", 12'(level), 12'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
